echo_buffer: RTL and testbench
==============================

# echo_buffer

Byte buffer and transmit sequencer between the UART receiver and the UART transmitter in the echo path. It captures each byte the receiver presents on `word`/`word_on_line` into a FIFO. It then hands the bytes to the transmitter one at a time using the `connection_status`/`transmit_ready` handshake. Back-to-back received bytes are therefore echoed without loss while the transmitter is busy.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- `WIDTH`, default 8: byte width.
- `START_TIMEOUT`, default 1023: maximum cycles to hold a start request without acknowledge.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `word`  in  WIDTH: received byte, valid while `word_on_line` is high.
- `word_on_line`  in  1: receiver byte-valid level; may stay high for several cycles.
- `transmit_ready`  in  1: transmitter idle when high.
- `tx_word`  out  WIDTH: byte presented to the transmitter.
- `connection_status`  out  1: start request to the transmitter.
- `fifo_count`  out  DEPTH_LOG2+1: current occupancy.
- `empty`  out  1: `fifo_count == 0`.
- `overflow`  out  1: sticky; a byte was dropped.

## Operation
- **Capture**
  - Rising edge of `word_on_line` (registered previous value 0, current value 1) pushes `word` exactly once.
  - A held level never pushes twice.
- **Full FIFO**
  - If `fifo_count == 2^DEPTH_LOG2` at the push cycle, the byte is dropped and `overflow` is set.
  - This applies even if a pop occurs in the same cycle.
  - `overflow` clears only on `rst`.
- **Pointers**
  - Read and write pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - Occupancy is tracked by a separate counter.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
- **Transmit FSM states**
  - IDLE: when `!empty && transmit_ready`, go to LOAD.
  - LOAD: `tx_word <= mem[rd]`, pop (rd++, count--), go to START.
  - START: `connection_status = 1`.
    - If `transmit_ready == 0`, go to BUSY.
    - Otherwise, if the timeout counter reaches START_TIMEOUT, go to IDLE; the byte is discarded.
  - BUSY: `connection_status = 0`; go to IDLE when `transmit_ready == 1`.
- **Stability:** `tx_word` is stable from LOAD until the FSM next enters LOAD.
- **Reset values:** `tx_word = 0`, `connection_status = 0`, `fifo_count = 0`, `empty = 1`, `overflow = 0`, FSM = IDLE, pointers = 0, edge register = 0. FIFO memory is not reset.
- **Reset mid-operation:** `rst` during START or BUSY drops `connection_status` on the next edge. Any byte already handed to the transmitter is not re-sent.

## Timing
- Push latency: a `word_on_line` rise sampled at edge N makes `fifo_count` increment at edge N+1 (registered edge detect).
- Empty FIFO, transmitter idle: `connection_status` rises 3 edges after the edge where `word_on_line` was first sampled high (push, IDLE→LOAD, LOAD→START).
- `connection_status` falls on the edge after `transmit_ready` is first sampled low.
- Minimum turnaround between two start requests is 3 cycles after `transmit_ready` returns high.
- Timeout counts cycles spent in START; the counter clears on entering START.

## Configuration
- Macro: `ECHO_BUFFER_CRLF_EN`.
- **Defined:**
  - After a byte 0x0D completes BUSY→IDLE, the FSM issues a synthetic 0x0A transfer: LOAD loads 0x0A with no pop, then START and BUSY as normal.
  - The synthetic byte precedes any queued byte.
  - 0x0D,0x0A input yields 0x0D,0x0A,0x0A.
- **Undefined:** bytes are echoed verbatim; no pending-LF flag exists.

## Structure
- Shared package `echo_pkg` holds:
  - FSM state enum (IDLE, LOAD, START, BUSY);
  - constants `CR = 8'h0D` and `LF = 8'h0A`.
- One sub-module `echo_fifo` covers storage, pointers, count, full/empty and the drop-on-full rule.
- The top level holds the edge detect, FSM, timeout counter and CRLF logic.

## Test plan
- **Single byte:** 0x41 on `word`, `word_on_line` high 5 cycles, transmitter model drops `transmit_ready` 2 cycles after request.
  - Expect `connection_status` high 3 cycles after the sample.
  - `tx_word = 0x41`.
  - Exactly one transfer.
- **Burst:** 17 bytes 0x00..0x10 pushed with transmitter held busy.
  - `fifo_count` reaches 16.
  - `overflow = 1`; 0x10 is dropped.
  - After release, 0x00..0x0F are echoed in order and `empty = 1`.
- **Simultaneous push and pop:** push in the LOAD cycle.
  - `fifo_count` unchanged.
  - Order preserved.
- **Timeout:** request a transfer with `transmit_ready` stuck high.
  - `connection_status` drops after 1023 cycles in START.
  - FSM returns to IDLE.
  - Next byte is attempted.
- **Reset mid-operation:** assert `rst` in BUSY with 3 bytes queued.
  - Next edge: all outputs at reset values.
  - `fifo_count = 0`.
- **CRLF with `ECHO_BUFFER_CRLF_EN`:** input 0x0D, 0x42.
  - Transmitted sequence 0x0D, 0x0A, 0x42.
  - Without the macro: 0x0D, 0x42.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types and constants for the UART echo buffer: transmit FSM states
// and the carriage-return / line-feed byte values.
package echo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        BUSY  = 2'd3
    } state_t;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

endpackage

// File: rtl/echo_buffer_if.sv
// Receiver-side byte strobe and transmitter-side start/ready handshake of the
// echo path. The master drives received bytes and the transmitter's ready.
interface echo_buffer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] word;
    logic             word_on_line;
    logic             transmit_ready;
    logic [WIDTH-1:0] tx_word;
    logic             connection_status;

    modport master (
        output word,
        output word_on_line,
        output transmit_ready,
        input  tx_word,
        input  connection_status
    );

    modport slave (
        input  word,
        input  word_on_line,
        input  transmit_ready,
        output tx_word,
        output connection_status
    );
endinterface

// File: rtl/echo_fifo.sv
// Byte FIFO for the echo buffer: array storage with registered read, wrapping
// pointers, separate occupancy counter and a sticky drop-on-full flag.
module echo_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [WIDTH-1:0]      rd_data_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  full, wr_en, rd_en;

    // A push against a full FIFO is dropped even when a pop frees a slot
    // in the same cycle.
    always_comb begin
        full       = (count_q == FULL_COUNT);
        wr_en      = push && !full;
        rd_en      = pop && (count_q != '0);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (push && full);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; the head entry is read every cycle so it is ready
    // by the time the sequencer loads it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= push_data;
        end
        rd_data_q <= mem[rd_ptr_q];
    end

    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign overflow = overflow_q;

endmodule

// File: rtl/echo_buffer.sv
// Echo-path byte buffer and transmit sequencer. Optional macro
// ECHO_BUFFER_CRLF_EN appends a synthetic LF after every transmitted CR.
module echo_buffer
    import echo_pkg::*;
#(
    parameter int DEPTH_LOG2    = 4,
    parameter int WIDTH         = 8,
    parameter int START_TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    echo_buffer_if.slave         bus,
    output logic [DEPTH_LOG2:0]  fifo_count,
    output logic                 empty,
    output logic                 overflow
);
    localparam int TMO_W = $clog2(START_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic             wol_q, wol_d;
    logic             push_q, push_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] tx_word_q, tx_word_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             pop;
    logic [WIDTH-1:0] rd_data;
`ifdef ECHO_BUFFER_CRLF_EN
    logic             lf_pending_q, lf_pending_d;
`endif

    echo_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_q),
        .push_data(word_q),
        .pop      (pop),
        .rd_data  (rd_data),
        .count    (fifo_count),
        .empty    (empty),
        .overflow (overflow)
    );

    // Rising edge of the receiver strobe becomes a one-cycle registered push,
    // so a byte lands in the FIFO one edge after the strobe is first seen.
    always_comb begin
        wol_d  = bus.word_on_line;
        push_d = bus.word_on_line && !wol_q;
        word_d = bus.word;
    end

    always_comb begin
        state_d   = state_q;
        tx_word_d = tx_word_q;
        tmo_d     = tmo_q;
        pop       = 1'b0;
`ifdef ECHO_BUFFER_CRLF_EN
        lf_pending_d = lf_pending_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ECHO_BUFFER_CRLF_EN
                if (bus.transmit_ready && (lf_pending_q || !empty)) begin
                    state_d = LOAD;
                end
`else
                if (bus.transmit_ready && !empty) begin
                    state_d = LOAD;
                end
`endif
            end
            LOAD: begin
                tmo_d   = '0;
                state_d = START;
`ifdef ECHO_BUFFER_CRLF_EN
                if (lf_pending_q) begin
                    tx_word_d    = WIDTH'(LF);
                    lf_pending_d = 1'b0;
                end else begin
                    tx_word_d = rd_data;
                    pop       = 1'b1;
                end
`else
                tx_word_d = rd_data;
                pop       = 1'b1;
`endif
            end
            START: begin
                // An unanswered request is abandoned after START_TIMEOUT
                // cycles; the popped byte is not retried.
                if (!bus.transmit_ready) begin
                    state_d = BUSY;
                end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            BUSY: begin
                if (bus.transmit_ready) begin
                    state_d = IDLE;
`ifdef ECHO_BUFFER_CRLF_EN
                    if (tx_word_q == WIDTH'(CR)) begin
                        lf_pending_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wol_q     <= 1'b0;
            push_q    <= 1'b0;
            word_q    <= '0;
            tx_word_q <= '0;
            tmo_q     <= '0;
`ifdef ECHO_BUFFER_CRLF_EN
            lf_pending_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wol_q     <= wol_d;
            push_q    <= push_d;
            word_q    <= word_d;
            tx_word_q <= tx_word_d;
            tmo_q     <= tmo_d;
`ifdef ECHO_BUFFER_CRLF_EN
            lf_pending_q <= lf_pending_d;
`endif
        end
    end

    assign bus.tx_word           = tx_word_q;
    assign bus.connection_status = (state_q == START);

endmodule

// File: tb/tb_echo_buffer.sv
// Self-checking bench for echo_buffer: a transmitter model records every
// started transfer and a queue model predicts the transmitted byte stream.
module tb_echo_buffer;
    import echo_pkg::*;

    localparam int DEPTH_LOG2    = 4;
    localparam int WIDTH         = 8;
    localparam int START_TIMEOUT = 1023;
    localparam int M_NORMAL      = 0;
    localparam int M_HOLD        = 1;
    localparam int M_STUCK       = 2;

    logic clk = 1'b0;
    logic rst;
    logic [DEPTH_LOG2:0] fifo_count;
    logic empty;
    logic overflow;

    always #5 clk = ~clk;

    echo_buffer_if #(.WIDTH(WIDTH)) bus ();

    echo_buffer #(
        .DEPTH_LOG2   (DEPTH_LOG2),
        .WIDTH        (WIDTH),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fifo_count(fifo_count),
        .empty     (empty),
        .overflow  (overflow)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         mode     = M_NORMAL;
    int         busy_len = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // Reference stream: every accepted byte is echoed; with the CRLF option
    // each CR is followed by an LF ahead of anything still queued.
    task automatic add_exp(input logic [7:0] b);
        exp_q.push_back(b);
`ifdef ECHO_BUFFER_CRLF_EN
        if (b == CR) exp_q.push_back(LF);
`endif
    endtask

    task automatic push_byte(input logic [7:0] b, input int hold, input int gap);
        bus.word         = b;
        bus.word_on_line = 1'b1;
        repeat (hold) @(negedge clk);
        bus.word_on_line = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), obs_q[i], exp_q[i]);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Transmitter model: acknowledges a start request two cycles after seeing
    // it, stays busy for busy_len (or a random 1..4) cycles, then goes idle.
    initial begin
        logic [7:0] seen;
        int         blen;
        bus.transmit_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (mode == M_HOLD) begin
                bus.transmit_ready = 1'b0;
            end else begin
                bus.transmit_ready = 1'b1;
                if (mode == M_NORMAL && bus.connection_status) begin
                    seen = bus.tx_word;
                    obs_q.push_back(seen);
                    $display("xfer %0d: tx_word=0x%02h", obs_q.size(), seen);
                    repeat (2) @(negedge clk);
                    bus.transmit_ready = 1'b0;
                    @(negedge clk);
                    check("cs_fall", bus.connection_status, 1'b0);
                    check("tx_stable", bus.tx_word, seen);
                    blen = (busy_len > 0) ? busy_len : $urandom_range(1, 4);
                    repeat (blen) @(negedge clk);
                    bus.transmit_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] a, b, y, b1;
        int t, hi, lo, n;

        rst              = 1'b1;
        bus.word         = '0;
        bus.word_on_line = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_word", bus.tx_word, 0);
        check("rst_cs", bus.connection_status, 0);
        check("rst_count", fifo_count, 0);
        check("rst_empty", empty, 1);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte with cycle-exact request timing.
        bus.word         = 8'h41;
        bus.word_on_line = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("sb_push_lat", fifo_count, 1);
        check("sb_cs_n1", bus.connection_status, 0);
        @(negedge clk);
        check("sb_cs_n2", bus.connection_status, 0);
        @(negedge clk);
        check("sb_cs_n3", bus.connection_status, 1);
        check("sb_tx_word", bus.tx_word, 8'h41);
        check("sb_pop", fifo_count, 0);
        @(negedge clk);
        bus.word_on_line = 1'b0;
        add_exp(8'h41);
        wait_drain();
        compare_stream("single");

        // Burst into a held-off transmitter; the 17th byte must be dropped.
        mode = M_HOLD;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1, 1);
        repeat (2) @(negedge clk);
        check("burst_full_cnt", fifo_count, 16);
        check("burst_no_ovf", overflow, 0);
        check("burst_not_empty", empty, 0);
        push_byte(8'h10, 1, 1);
        repeat (2) @(negedge clk);
        check("burst_drop_cnt", fifo_count, 16);
        check("burst_ovf", overflow, 1);
        for (int i = 0; i < 16; i++) add_exp(8'(i));
        mode = M_NORMAL;
        wait_drain();
        compare_stream("burst");
        check("burst_empty", empty, 1);
        check("burst_cnt0", fifo_count, 0);
        check("ovf_sticky", overflow, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 0);

        // Push landing on the same edge as the pop.
        for (int it = 0; it < 4; it++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            bus.word         = a;
            bus.word_on_line = 1'b1;
            @(negedge clk);
            bus.word_on_line = 1'b0;
            @(negedge clk);
            check("simul_cnt_n1", fifo_count, 1);
            bus.word         = b;
            bus.word_on_line = 1'b1;
            @(negedge clk);
            bus.word_on_line = 1'b0;
            @(negedge clk);
            check("simul_cnt", fifo_count, 1);
            check("simul_cs", bus.connection_status, 1);
            check("simul_tx", bus.tx_word, a);
            add_exp(a);
            add_exp(b);
            wait_drain();
            compare_stream($sformatf("simul%0d", it));
        end

        // Start request never acknowledged: abandoned after START_TIMEOUT.
        y    = 8'($urandom_range(16, 255));
        mode = M_HOLD;
        repeat (2) @(negedge clk);
        push_byte(8'h55, 1, 1);
        push_byte(y, 1, 1);
        repeat (2) @(negedge clk);
        check("tmo_pre_cnt", fifo_count, 2);
        mode = M_STUCK;
        t = 0;
        while (!bus.connection_status && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("tmo_rise", bus.connection_status, 1);
        hi = 0;
        while (bus.connection_status && hi < 1100) begin
            hi++;
            @(negedge clk);
        end
        check("tmo_hi_cycles", hi, START_TIMEOUT);
        lo = 0;
        while (!bus.connection_status && lo < 20) begin
            lo++;
            @(negedge clk);
        end
        check("tmo_gap", lo, 2);
        check("tmo_next_cnt", fifo_count, 0);
        mode = M_NORMAL;
        add_exp(y);
        wait_drain();
        compare_stream("tmo");

        // Reset while the transmitter is busy with three bytes queued.
        busy_len = 30;
        b1       = 8'($urandom_range(16, 255));
        push_byte(b1, 1, 1);
        t = 0;
        while (obs_q.size() == 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(16, 255)), 1, 1);
        repeat (2) @(negedge clk);
        check("rmid_pre_cnt", fifo_count, 3);
        check("rmid_pre_cs", bus.connection_status, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rmid_tx_word", bus.tx_word, 0);
        check("rmid_cs", bus.connection_status, 0);
        check("rmid_cnt", fifo_count, 0);
        check("rmid_empty", empty, 1);
        check("rmid_ovf", overflow, 0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        add_exp(b1);
        compare_stream("rmid");
        busy_len = 0;

        // CR handling (LF insertion only when the option is built in).
        push_byte(CR, 2, 1);
        push_byte(8'h42, 2, 1);
        add_exp(CR);
        add_exp(8'h42);
        wait_drain();
        compare_stream("crlf");

        // Random byte groups with random strobe lengths and gaps.
        for (int g = 0; g < 6; g++) begin
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom_range(0, 255));
                push_byte(b, $urandom_range(1, 4), $urandom_range(1, 3));
                add_exp(b);
            end
            wait_drain();
            compare_stream($sformatf("rnd%0d", g));
            check("rnd_empty", empty, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
